// File: rtl/kadder_pkg.sv
// Shared defaults, geometry check and slice-result type for the pipelined adder.
package kadder_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
  localparam int DEF_CHUNK  = DEF_WIDTH / DEF_STAGES;

  // Slice result at the default geometry; stages declare the same shape at their own CHUNK.
  typedef struct packed {
    logic [DEF_CHUNK-1:0] s;
    logic                 c;
  } chunk_sum_t;

  function automatic bit geometry_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction
endpackage

// File: rtl/kadd_stage.sv
// One CHUNK-bit adder slice with its pipeline register and valid/ready handshake.
module kadd_stage
  import kadder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int IDX   = 0,
  parameter bit LAST  = 1'b0,
  localparam int LO_IN = IDX * CHUNK,
  localparam int HI_IN = WIDTH - LO_IN,
  localparam int W_IN  = 2 * HI_IN + LO_IN,
  localparam int W_OUT = W_IN - CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_v,
  output logic             o_rdy,
  input  logic             i_rdy,
  input  logic [W_IN-1:0]  i_w,
  input  logic             i_c,
  output logic             o_v,
  output logic [W_OUT-1:0] o_w,
  output logic             o_c,
  output logic             o_ovf
);
  typedef struct packed {
    logic [CHUNK-1:0] s;
    logic             c;
  } slice_t;

  // Word layout from bit 0: resolved sum bits, remaining b chunks, remaining a chunks.
  // The new sum chunk lands where the consumed b chunk was; the a field slides down.
  localparam logic [W_OUT-1:0] S_MASK = W_OUT'({CHUNK{1'b1}}) << LO_IN;
  localparam logic [W_OUT-1:0] A_MASK = {W_OUT{1'b1}} << (LO_IN + HI_IN);

  logic [CHUNK-1:0] w_a, w_b;
  logic [W_OUT-1:0] w_nxt;
  logic             w_msbc;
  slice_t           w_add;

  logic             r_v, r_c, r_ovf;
  logic [W_OUT-1:0] r_w;

  assign w_a = i_w[LO_IN + HI_IN +: CHUNK];
  assign w_b = i_w[LO_IN +: CHUNK];

  always_comb begin
    w_add = '0;
    {w_add.c, w_add.s} = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, i_c};
  end

  assign w_msbc = w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_add.s[CHUNK-1];
  assign w_nxt  = (i_w[W_OUT-1:0] & ~(S_MASK | A_MASK))
                | (W_OUT'(i_w >> CHUNK) & A_MASK)
                | (W_OUT'(w_add.s) << LO_IN);

  assign o_rdy = !r_v || i_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= 1'b0;
      r_w   <= '0;
      r_c   <= 1'b0;
      r_ovf <= 1'b0;
    end else if (o_rdy) begin
      r_v <= i_v;
      if (i_v) begin
        r_w   <= w_nxt;
        r_c   <= w_add.c;
        r_ovf <= LAST & (w_msbc ^ w_add.c);
      end
    end
  end

  assign o_v   = r_v;
  assign o_w   = r_w;
  assign o_c   = r_c;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/kpipe_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split over STAGES registered slices,
// carry moves one slice per cycle, one add accepted per cycle, valid/ready on both sides.
module kpipe_adder
  import kadder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int CHUNK = WIDTH / STAGES;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("kpipe_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_v, w_ovf;

  assign w_rdy[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_st
    localparam int LO_IN = i * CHUNK;
    localparam int HI_IN = WIDTH - LO_IN;
    localparam int W_IN  = 2 * HI_IN + LO_IN;
    localparam int W_OUT = W_IN - CHUNK;

    logic [W_IN-1:0]  w_wi;
    logic [W_OUT-1:0] w_wo;
    logic             w_ci, w_vi, w_co;

    if (i == 0) begin : g_head
      assign w_wi = {a, b};
      assign w_ci = c_in;
      assign w_vi = in_valid;
    end else begin : g_link
      assign w_wi = g_st[i-1].w_wo;
      assign w_ci = g_st[i-1].w_co;
      assign w_vi = w_v[i-1];
    end

    kadd_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (i),
      .LAST  (i == STAGES - 1)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .i_v   (w_vi),
      .o_rdy (w_rdy[i]),
      .i_rdy (w_rdy[i+1]),
      .i_w   (w_wi),
      .i_c   (w_ci),
      .o_v   (w_v[i]),
      .o_w   (w_wo),
      .o_c   (w_co),
      .o_ovf (w_ovf[i])
    );
  end

  assign in_ready  = w_rdy[0] & ~rst;
  assign out_valid = w_v[STAGES-1];
  assign sum       = g_st[STAGES-1].w_wo;
  assign c_out     = g_st[STAGES-1].w_co;
  // Only the top slice reports overflow; the others hold zero.
  assign overflow  = |w_ovf;
endmodule

// File: tb/tb_kpipe_adder.sv
// Directed bench for kpipe_adder: 16-bit/4-stage instance plus a 1-bit/1-stage instance.
module tb_kpipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, overflow;
  logic [15:0] a, b, sum;
  logic        d_in_valid, d_in_ready, d_c_in, d_out_valid, d_out_ready, d_c_out, d_overflow;
  logic [0:0]  d_a, d_b, d_sum;

  int vectors = 0;
  int miscompares = 0;

  kpipe_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .overflow(overflow)
  );

  kpipe_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
    .c_in(d_c_in), .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum),
    .c_out(d_c_out), .overflow(d_overflow)
  );

  // Issues one op into an empty pipe and waits (bounded) for its result.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        output int lat, output logic [15:0] s, output logic co,
                        output logic ov, output logic got);
    @(negedge clk);
    a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    got = 1'b0; lat = 0; s = '0; co = 1'b0; ov = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (out_valid) begin
        got = 1'b1; s = sum; co = c_out; ov = overflow;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL reset_sum got %h want 0000", sum); end
    vectors++; if (c_out !== 1'b0) begin miscompares++; $display("FAIL reset_c_out got %b want 0", c_out); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    int lat; logic [15:0] s; logic co, ov, got;
    run_op(16'h1234, 16'h0FFF, 1'b0, lat, s, co, ov, got);
    vectors++; if (!got || lat !== 4) begin miscompares++; $display("FAIL single_latency got %0d (seen %b) want 4", lat, got); end
    vectors++; if (s !== 16'h2233) begin miscompares++; $display("FAIL single_sum got %h want 2233", s); end
    vectors++; if ({co, ov} !== 2'b00) begin miscompares++; $display("FAIL single_flags got c=%b v=%b want c=0 v=0", co, ov); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_carry_chain();
    int lat; logic [15:0] s; logic co, ov, got;
    run_op(16'hFFFF, 16'h0000, 1'b1, lat, s, co, ov, got);
    vectors++; if (!got || lat !== 4) begin miscompares++; $display("FAIL carry_latency got %0d (seen %b) want 4", lat, got); end
    vectors++; if ({s, co, ov} !== {16'h0000, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL carry_result got %h c=%b v=%b want 0000 c=1 v=0", s, co, ov);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] s; logic co, ov, got;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat, s, co, ov, got);
    vectors++; if (!got || lat !== 4) begin miscompares++; $display("FAIL ovf_latency got %0d (seen %b) want 4", lat, got); end
    vectors++; if ({s, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL ovf_result got %h c=%b v=%b want 8000 c=0 v=1", s, co, ov);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 16'h0100 * (k + 1); b = 16'h0011; c_in = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++; if ({out_valid, sum, c_out, overflow} !== 19'd0) begin
      miscompares++; $display("FAIL midrst_clear got v=%b %h c=%b o=%b want all 0", out_valid, sum, c_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_ghost got result after reset want none"); end
  endtask

  task automatic test_backpressure();
    logic [15:0] va [8] = '{16'h0001, 16'h8000, 16'h00FF, 16'h1111, 16'hFFFF, 16'h4000, 16'hABCD, 16'h0F0F};
    logic [15:0] vb [8] = '{16'h0001, 16'h8000, 16'h0001, 16'h2222, 16'hFFFF, 16'h4000, 16'h1234, 16'hF0F0};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [17:0] ex [8] = '{{16'h0002, 2'b00}, {16'h0000, 2'b11}, {16'h0100, 2'b00}, {16'h3334, 2'b00},
                            {16'hFFFF, 2'b10}, {16'h8000, 2'b01}, {16'hBE01, 2'b00}, {16'h0000, 2'b10}};
    int ni, no;
    logic saw_full, stalled;
    logic [17:0] held;
    ni = 0; no = 0; saw_full = 1'b0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && no < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 9);
      in_valid = (ni < 8);
      if (ni < 8) begin a = va[ni]; b = vb[ni]; c_in = vc[ni]; end
      #1;
      if (stalled) begin
        vectors++;
        if (!out_valid || {sum, c_out, overflow} !== held) begin
          miscompares++; $display("FAIL bp_stall_stable cyc %0d got v=%b %h want v=1 %h", cyc, out_valid, {sum, c_out, overflow}, held);
        end
      end
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        vectors++;
        if ({sum, c_out, overflow} !== ex[no]) begin
          miscompares++; $display("FAIL bp_result[%0d] got %h want %h", no, {sum, c_out, overflow}, ex[no]);
        end
        no++;
      end
      stalled = out_valid && !out_ready;
      held = {sum, c_out, overflow};
      if (in_valid && in_ready) ni++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (no !== 8) begin miscompares++; $display("FAIL bp_count got %0d want 8", no); end
    vectors++; if (saw_full !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready_drop got %b want 1", saw_full); end
    repeat (6) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_degenerate();
    // {sum, c_out, overflow} for index {a, b, c_in}
    logic [2:0] exp1 [8] = '{3'b000, 3'b101, 3'b100, 3'b010, 3'b100, 3'b010, 3'b011, 3'b110};
    logic [2:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      @(negedge clk);
      d_a = idx[2]; d_b = idx[1]; d_c_in = idx[0]; d_in_valid = 1'b1; d_out_ready = 1'b1;
      @(negedge clk);
      d_in_valid = 1'b0;
      vectors++;
      if (d_out_valid !== 1'b1 || {d_sum, d_c_out, d_overflow} !== exp1[i]) begin
        miscompares++; $display("FAIL w1_case%0d got v=%b %b want v=1 %b", i, d_out_valid, {d_sum, d_c_out, d_overflow}, exp1[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_a = '0; d_b = '0; d_c_in = 1'b0;
    test_reset();
    test_single();
    test_carry_chain();
    test_overflow();
    test_reset_midflight();
    test_backpressure();
    test_degenerate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
